// File: rtl/estimation_top_if.sv
// Bundle between the source-estimation stage and its producer/consumer.
// Carries: en (start request), Z_IN (whitened data), W_MAT (unmixing matrix),
// S_EST (estimated sources) and est_opvld (result-valid flag).
// Flat matrices are declared [0:N-1]; element (r,c) sits at index (r*cols+c)*DATA_WIDTH.
interface estimation_top_if #(
    parameter int DATA_WIDTH = 16,
    parameter int DIM        = 3,
    parameter int SAMPLES    = 4
);
    logic                                  en;
    logic [0:DATA_WIDTH*DIM*SAMPLES-1]     Z_IN;
    logic [0:DATA_WIDTH*DIM*DIM-1]         W_MAT;
    logic [0:DATA_WIDTH*DIM*SAMPLES-1]     S_EST;
    logic                                  est_opvld;

    // master: whoever requests the computation and consumes the result
    modport master (output en, Z_IN, W_MAT, input S_EST, est_opvld);
    // slave: the estimation stage itself
    modport slave  (input en, Z_IN, W_MAT, output S_EST, est_opvld);
endinterface

// File: rtl/estimation_top.sv
// Source estimation S = W^T * Z using one shared signed MAC, one product per clock.
// Latency: start edge + DIM*DIM*SAMPLES MAC edges; est_opvld visible one edge after the last MAC.
// Ports: clk, rst (sync active-high), io (slave modport: en, Z_IN, W_MAT in; S_EST, est_opvld out).
module estimation_top #(
    parameter int DATA_WIDTH = 16,
    parameter int DIM        = 3,
    parameter int SAMPLES    = 4,
    parameter int OUT_SHIFT  = 0
) (
    input  logic               clk,
    input  logic               rst,
    estimation_top_if.slave    io
);
    localparam int NZ    = DATA_WIDTH * DIM * SAMPLES;
    localparam int PW    = 2 * DATA_WIDTH;
    localparam int ACC_W = PW + $clog2(DIM);
    localparam int KW    = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int JW    = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                        state;
    logic signed [DATA_WIDTH-1:0]  z_r [DIM][SAMPLES];
    logic signed [DATA_WIDTH-1:0]  w_r [DIM][DIM];
    logic signed [ACC_W-1:0]       acc;
    logic [KW-1:0]                 k;
    logic [KW-1:0]                 i;
    logic [JW-1:0]                 j;
    logic [0:NZ-1]                 s_r;
    logic                          opvld_r;

    logic signed [PW-1:0]          prod;
    logic signed [ACC_W-1:0]       sum;
    logic signed [ACC_W-1:0]       shifted;
    logic signed [DATA_WIDTH-1:0]  sat_val;

    // Column i of W is weight vector i, so S[i][j] walks W down column i.
    always_comb begin
        prod    = PW'(w_r[k][i]) * PW'(z_r[k][j]);
        sum     = acc + ACC_W'(prod);
        shifted = sum >>> OUT_SHIFT;
        if (shifted > SAT_MAX) begin
            sat_val = SAT_MAX[DATA_WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            sat_val = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            sat_val = shifted[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            opvld_r <= 1'b0;
            s_r     <= '0;
            acc     <= '0;
            k       <= '0;
            j       <= '0;
            i       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (io.en) begin
                        // Snapshot operands so the run is immune to later input changes.
                        for (int r = 0; r < DIM; r++) begin
                            for (int c = 0; c < SAMPLES; c++) begin
                                z_r[r][c] <= io.Z_IN[(r*SAMPLES+c)*DATA_WIDTH +: DATA_WIDTH];
                            end
                            for (int c = 0; c < DIM; c++) begin
                                w_r[r][c] <= io.W_MAT[(r*DIM+c)*DATA_WIDTH +: DATA_WIDTH];
                            end
                        end
                        acc   <= '0;
                        k     <= '0;
                        j     <= '0;
                        i     <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (k == KW'(DIM-1)) begin
                        // Last term of this dot product: commit and restart the accumulator.
                        s_r[(int'(i)*SAMPLES + int'(j))*DATA_WIDTH +: DATA_WIDTH] <= sat_val;
                        acc <= '0;
                        k   <= '0;
                        if (j == JW'(SAMPLES-1)) begin
                            j <= '0;
                            if (i == KW'(DIM-1)) begin
                                i     <= '0;
                                state <= DONE;
                            end else begin
                                i <= i + 1'b1;
                            end
                        end else begin
                            j <= j + 1'b1;
                        end
                    end else begin
                        acc <= sum;
                        k   <= k + 1'b1;
                    end
                end
                DONE: begin
                    // The valid flag is raised on the first DONE edge regardless of en,
                    // so every run produces at least one visible valid cycle.
                    if (!opvld_r) begin
                        opvld_r <= 1'b1;
                    end else if (!io.en) begin
                        opvld_r <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign io.S_EST     = s_r;
    assign io.est_opvld = opvld_r;
endmodule

// File: tb/tb_estimation_top.sv
// Bench for estimation_top: matrix-level reference model plus directed runs.
module tb_estimation_top;
    localparam int DW  = 16;
    localparam int DIM = 3;
    localparam int SMP = 4;
    localparam int NZ  = DW * DIM * SMP;
    localparam int NW  = DW * DIM * DIM;

    typedef logic [0:NZ-1] zvec_t;
    typedef logic [0:NW-1] wvec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    estimation_top_if #(.DATA_WIDTH(DW), .DIM(DIM), .SAMPLES(SMP)) bus  ();
    estimation_top_if #(.DATA_WIDTH(DW), .DIM(DIM), .SAMPLES(SMP)) bus2 ();

    estimation_top #(.DATA_WIDTH(DW), .DIM(DIM), .SAMPLES(SMP), .OUT_SHIFT(0)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    estimation_top #(.DATA_WIDTH(DW), .DIM(DIM), .SAMPLES(SMP), .OUT_SHIFT(15)) dut2 (
        .clk (clk),
        .rst (rst),
        .io  (bus2)
    );

    int cmp_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string name, input logic [NZ-1:0] act, input logic [NZ-1:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] sel(input zvec_t v, input int r, input int c);
        return v[(r*SMP+c)*DW +: DW];
    endfunction

    // Reference: S = sat((W^T * Z) >>> sh), computed on whole matrices with plain integers.
    function automatic zvec_t ref_s(input zvec_t z, input wvec_t w, input int sh);
        zvec_t  res;
        longint acc;
        res = '0;
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < SMP; j++) begin
                acc = 0;
                for (int k = 0; k < DIM; k++) begin
                    acc += longint'($signed(w[(k*DIM+i)*DW +: DW])) *
                           longint'($signed(z[(k*SMP+j)*DW +: DW]));
                end
                acc = acc >>> sh;
                if (acc > 32767)  acc = 32767;
                if (acc < -32768) acc = -32768;
                res[(i*SMP+j)*DW +: DW] = DW'(acc);
            end
        end
        return res;
    endfunction

    // Timeline model: 0 = idle, 1 = computing, 2 = result complete.
    int    phase = 0;
    int    cnt   = 0;
    logic  m_vld = 1'b0;
    zvec_t m_s   = '0;
    zvec_t m_next = '0;

    always @(posedge clk) begin
        if (rst) begin
            phase = 0;
            m_vld = 1'b0;
            m_s   = '0;
        end else begin
            case (phase)
                0: if (bus.en) begin
                    m_next = ref_s(bus.Z_IN, bus.W_MAT, 0);
                    cnt    = 0;
                    phase  = 1;
                end
                1: begin
                    cnt++;
                    if (cnt == DIM*DIM*SMP) begin
                        m_s   = m_next;
                        phase = 2;
                    end
                end
                default: begin
                    if (!m_vld) begin
                        m_vld = 1'b1;
                    end else if (!bus.en) begin
                        m_vld = 1'b0;
                        phase = 0;
                    end
                end
            endcase
        end
    end

    // Every cycle: the valid flag must follow the model; S_EST is checked whenever
    // it is defined (not mid-computation, where partial updates are allowed).
    always @(negedge clk) begin
        chk("model_opvld", NZ'(bus.est_opvld), NZ'(m_vld));
        if (phase != 1) chk("model_s_est", bus.S_EST, m_s);
    end

    task automatic wait_vld(input int which, output int lat);
        logic found;
        found = 1'b0;
        lat   = -1;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            @(negedge clk);
            if ((which == 0) ? bus.est_opvld : bus2.est_opvld) begin
                lat   = n;
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            cmp_cnt++;
            err_cnt++;
            $display("FAIL timeout_dut%0d: est_opvld never rose, required within 100 edges", which);
        end
    endtask

    zvec_t zv;
    wvec_t wv;
    zvec_t zv2;
    wvec_t wv2;
    int    lat;

    initial begin
        rst        = 1'b1;
        bus.en     = 1'b1;
        bus.Z_IN   = '0;
        bus.W_MAT  = '0;
        bus2.en    = 1'b0;
        bus2.Z_IN  = '0;
        bus2.W_MAT = '0;

        // Reset with en high: nothing starts, outputs zero.
        repeat (2) @(negedge clk);
        chk("reset_s_est", bus.S_EST, '0);
        chk("reset_opvld", NZ'(bus.est_opvld), '0);
        rst    = 1'b0;
        bus.en = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_after_reset", NZ'(bus.est_opvld), '0);

        // Run 1: default fill W=Z=r+c with saturating overrides in column 0 and 1.
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < SMP; c++) zv[(r*SMP+c)*DW +: DW] = DW'(r + c);
            for (int c = 0; c < DIM; c++) wv[(r*DIM+c)*DW +: DW] = DW'(r + c);
        end
        wv[(0*DIM+0)*DW +: DW] = DW'(120);  wv[(1*DIM+0)*DW +: DW] = DW'(50); wv[(2*DIM+0)*DW +: DW] = DW'(80);
        zv[(0*SMP+0)*DW +: DW] = DW'(100);  zv[(1*SMP+0)*DW +: DW] = DW'(150); zv[(2*SMP+0)*DW +: DW] = DW'(200);
        wv[(0*DIM+1)*DW +: DW] = DW'(-120); wv[(1*DIM+1)*DW +: DW] = DW'(50); wv[(2*DIM+1)*DW +: DW] = DW'(-80);
        zv[(0*SMP+1)*DW +: DW] = DW'(100);  zv[(1*SMP+1)*DW +: DW] = DW'(-150); zv[(2*SMP+1)*DW +: DW] = DW'(200);
        bus.Z_IN  = zv;
        bus.W_MAT = wv;
        bus.en    = 1'b1;
        wait_vld(0, lat);
        chk("latency_edges", NZ'(lat), NZ'(37));
        chk("s00_pos_sat", NZ'(sel(bus.S_EST, 0, 0)), NZ'(16'h7FFF));   // 35500 clamps
        chk("s11_neg_sat", NZ'(sel(bus.S_EST, 1, 1)), NZ'(16'h8000));   // -35500 clamps
        chk("s23_plain",   NZ'(sel(bus.S_EST, 2, 3)), NZ'(16'd38));     // 2*3+3*4+4*5
        repeat (4) @(negedge clk);
        chk("vld_held_en_high", NZ'(bus.est_opvld), NZ'(1));
        bus.en = 1'b0;
        @(negedge clk);
        chk("vld_clear_en_low", NZ'(bus.est_opvld), '0);
        chk("s23_kept_idle", NZ'(sel(bus.S_EST, 2, 3)), NZ'(16'd38));

        // Run 2: en pulsed for one edge, inputs scrambled mid-run must not matter.
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < SMP; c++) zv[(r*SMP+c)*DW +: DW] = DW'(1000*(r+1) - 700*c);
            for (int c = 0; c < DIM; c++) wv[(r*DIM+c)*DW +: DW] = (r == c) ? DW'(2) : DW'(-(r + c));
        end
        bus.Z_IN  = zv;
        bus.W_MAT = wv;
        bus.en    = 1'b1;
        @(negedge clk);
        bus.en = 1'b0;
        repeat (3) @(negedge clk);
        bus.Z_IN  = ~zv;
        bus.W_MAT = '0;
        wait_vld(0, lat);
        chk("run2_s00", NZ'(sel(bus.S_EST, 0, 0)), NZ'(16'hE890));      // 2000-2000-6000
        @(negedge clk);
        chk("run2_vld_one_cycle", NZ'(bus.est_opvld), '0);

        // Abort: reset lands on CALC edge 10, then en still high restarts cleanly.
        bus.Z_IN  = zv;
        bus.W_MAT = wv;
        bus.en    = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_s_est", bus.S_EST, '0);
        chk("abort_opvld", NZ'(bus.est_opvld), '0);
        rst = 1'b0;
        wait_vld(0, lat);
        chk("after_abort_s00", NZ'(sel(bus.S_EST, 0, 0)), NZ'(16'hE890));
        bus.en = 1'b0;
        repeat (2) @(negedge clk);

        // Scaled instance: 0x4000*0x4000 >>> 15 = 0x2000, and the negative case.
        zv2 = '0;
        wv2 = '0;
        zv2[0 +: DW] = 16'h4000;
        wv2[0 +: DW] = 16'h4000;
        bus2.Z_IN  = zv2;
        bus2.W_MAT = wv2;
        bus2.en    = 1'b1;
        wait_vld(1, lat);
        chk("shift_pos", NZ'(sel(bus2.S_EST, 0, 0)), NZ'(16'h2000));
        bus2.en = 1'b0;
        repeat (2) @(negedge clk);
        wv2[0 +: DW] = 16'hC000;
        bus2.W_MAT = wv2;
        bus2.en    = 1'b1;
        wait_vld(1, lat);
        chk("shift_neg", NZ'(sel(bus2.S_EST, 0, 0)), NZ'(16'hE000));
        bus2.en = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
